note_source_arbiter: RTL and testbench
======================================

# note_source_arbiter

Arbitrates the piano's three note sources (1 = live keyboard, 2 = recorded playback, 3 = demo song) for the shared output selector. It drives the selector's one-hot address (1, 2, 4; 0 = silence) from per-source requests using fixed priority. A granted source is held for a minimum dwell, and every hand-over passes through a silent gap so switches do not click. The block sits between the source modules and the note selector; its address output wires directly to the selector's address input.

## Interface
- MIN_HOLD, 4: iTick pulses a grant must last before a higher-priority source may preempt it (0 = preemptible immediately).
- GAP_TICKS, 1: iTick pulses of silence (address 0) between releasing one grant and issuing the next.
- iClk  in  1  clock; all state changes on rising edge.
- iReset_n  in  1  reset; asynchronous, active-low.
- iTick  in  1  one-cycle timebase enable; counts toward both hold and gap.
- iReq  in  3  request per source; bit0 = source 1 (highest priority), bit2 = source 3 (lowest).
- oAddress  out  4  registered selector address: 4'd1, 4'd2, 4'd4 or 4'd0.
- oOwner  out  2  registered current owner: 0 = none, 1..3 = source number.
- oPreempt  out  1  one-cycle pulse; the current grant was ended by preemption.

## Operation
- States: IDLE (address 0), GRANT (address = owner's one-hot), GAP (address 0).
- Priority: source 1 > source 2 > source 3, fixed; no round-robin.
- IDLE:
  - If any iReq bit is set → GRANT to the highest-priority requester, with the hold counter cleared.
  - Otherwise stay in IDLE.
- GRANT:
  - Owner's iReq low → GAP (release). oPreempt stays 0.
  - Else, if the hold counter equals MIN_HOLD and a higher-priority iReq is high → GAP and pulse oPreempt for one cycle.
  - Else stay in GRANT. Lower-priority requests are ignored.
  - The hold counter increments on each iTick while in GRANT and saturates at MIN_HOLD.
- GAP:
  - The gap counter is cleared on entry.
  - Each cycle: if the gap counter equals GAP_TICKS, exit; otherwise increment it on iTick.
  - Exit goes to GRANT for the highest-priority requester present at that cycle, or to IDLE if none.
  - The previous owner may win again.
- Counter widths: ceil(log2(MAX+1)) bits each; they never wrap.
- Simultaneous events:
  - Owner release coinciding with preemption eligibility counts as a release; oPreempt is 0.
  - A state transition coinciding with iTick: the transition wins and the new state's counter starts at 0, so that tick is not counted.
- iReq is not latched. A request withdrawn before the arbiter samples it is never granted.
- Reset (at any time, including mid-GRANT or mid-GAP):
  - Immediately forces IDLE, oAddress = 0, oOwner = 0, oPreempt = 0 and both counters = 0.
  - After deassertion, the first rising edge evaluates IDLE normally.

## Timing
- Request to grant from IDLE: iReq sampled at edge N; oAddress/oOwner valid after edge N. The downstream selector registers once more, so note data appears after edge N+1.
- Release: owner's iReq low at edge N → oAddress = 0 after edge N.
- GAP duration:
  - GAP_TICKS = 0: exactly one clock cycle.
  - Otherwise: the cycles until the GAP_TICKS-th iTick pulse, plus one.
- Preemption: earliest at the edge where the hold counter already equals MIN_HOLD. oPreempt is high for the single cycle after that edge, which is also the first GAP cycle.
- oAddress and oOwner always change together and never show a non-one-hot address.

## Test plan
- Reset mid-grant: source 2 granted (oAddress = 2); pulse iReset_n low for 3 cycles → oAddress = 0 and oOwner = 0 asynchronously. With iReq = 3'b010 held, the first edge after release gives oAddress = 2.
- Priority from IDLE: iReq = 3'b110 → oAddress = 2, oOwner = 2 one edge later. Drop bit1 → address 0 for the GAP, then oAddress = 4.
- Minimum hold (MIN_HOLD = 4, GAP_TICKS = 1, iTick every 10 cycles): source 3 granted, then raise bit0 → no switch before the 4th tick. One cycle after the 4th tick the grant ends, oPreempt = 1 for one cycle, oAddress = 0 until the next tick plus one cycle, then oAddress = 1.
- Release with re-grant: source 1 alone, drops and re-raises during GAP → after GAP, oAddress = 1 again and oPreempt stays 0 throughout.
- Simultaneous release and preemption: source 2 held past MIN_HOLD; in the same cycle bit1 falls and bit0 rises → oPreempt = 0, GAP entered, then oAddress = 1.
- GAP_TICKS = 0, MIN_HOLD = 0: source 3 granted, bit0 raised → exactly one cycle of address 0, then oAddress = 1, with oPreempt pulsed once.

Source files
------------

// File: rtl/note_source_arbiter.sv
// Fixed-priority arbiter for the three piano note sources: drives the note selector's
// one-hot address, enforces a minimum grant dwell and a silent gap on every hand-over.
module note_source_arbiter #(
  parameter int MIN_HOLD  = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iTick,
  input  logic [2:0] iReq,
  output logic [3:0] oAddress,
  output logic [1:0] oOwner,
  output logic       oPreempt
);

  localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_r;
  logic [HOLD_W-1:0] holdCnt_r;
  logic [GAP_W-1:0]  gapCnt_r;
  logic              ownerReq_s;
  logic              higherReq_s;
  logic [1:0]        nextOwner_s;

  function automatic logic [1:0] pickOwner(input logic [2:0] req);
    if (req[0]) begin
      return 2'd1;
    end else if (req[1]) begin
      return 2'd2;
    end else if (req[2]) begin
      return 2'd3;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic [3:0] ownerToAddr(input logic [1:0] owner);
    case (owner)
      2'd1:    return 4'd1;
      2'd2:    return 4'd2;
      2'd3:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // Decode the current owner's own request and any strictly higher-priority request.
  always_comb begin
    ownerReq_s  = 1'b0;
    higherReq_s = 1'b0;
    nextOwner_s = pickOwner(iReq);
    case (oOwner)
      2'd1: begin
        ownerReq_s  = iReq[0];
        higherReq_s = 1'b0;
      end
      2'd2: begin
        ownerReq_s  = iReq[1];
        higherReq_s = iReq[0];
      end
      2'd3: begin
        ownerReq_s  = iReq[2];
        higherReq_s = |iReq[1:0];
      end
      default: begin
        ownerReq_s  = 1'b0;
        higherReq_s = 1'b0;
      end
    endcase
  end

  // Arbitration FSM; address and owner are only ever written as a pair.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_r   <= IDLE;
      holdCnt_r <= '0;
      gapCnt_r  <= '0;
      oAddress  <= 4'd0;
      oOwner    <= 2'd0;
      oPreempt  <= 1'b0;
    end else begin
      oPreempt <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|iReq) begin
            state_r   <= GRANT;
            holdCnt_r <= '0;
            oOwner    <= nextOwner_s;
            oAddress  <= ownerToAddr(nextOwner_s);
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          // Release takes precedence over preemption, so a coincident release never pulses oPreempt.
          if (!ownerReq_s) begin
            state_r  <= GAP;
            gapCnt_r <= '0;
            oOwner   <= 2'd0;
            oAddress <= 4'd0;
          end else if ((holdCnt_r == HOLD_MAX) && higherReq_s) begin
            state_r  <= GAP;
            gapCnt_r <= '0;
            oOwner   <= 2'd0;
            oAddress <= 4'd0;
            oPreempt <= 1'b1;
          end else if (iTick && (holdCnt_r != HOLD_MAX)) begin
            holdCnt_r <= holdCnt_r + HOLD_W'(1);
          end else begin
            holdCnt_r <= holdCnt_r;
          end
        end
        GAP: begin
          if (gapCnt_r == GAP_MAX) begin
            if (|iReq) begin
              state_r   <= GRANT;
              holdCnt_r <= '0;
              oOwner    <= nextOwner_s;
              oAddress  <= ownerToAddr(nextOwner_s);
            end else begin
              state_r <= IDLE;
            end
          end else if (iTick) begin
            gapCnt_r <= gapCnt_r + GAP_W'(1);
          end else begin
            gapCnt_r <= gapCnt_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          holdCnt_r <= '0;
          gapCnt_r  <= '0;
          oAddress  <= 4'd0;
          oOwner    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_source_arbiter.sv
// Directed bench for note_source_arbiter: default instance (MIN_HOLD=4, GAP_TICKS=1)
// plus a zero-hold/zero-gap instance.
module tb_note_source_arbiter;

  logic       iClk;
  logic       iReset_n;
  logic       iTick;
  logic [2:0] iReq;
  logic [3:0] oAddress;
  logic [1:0] oOwner;
  logic       oPreempt;

  logic       zTick;
  logic [2:0] zReq;
  logic [3:0] zAddress;
  logic [1:0] zOwner;
  logic       zPreempt;

  int nCompared;
  int nMismatched;

  note_source_arbiter #(.MIN_HOLD(4), .GAP_TICKS(1)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iTick(iTick), .iReq(iReq),
    .oAddress(oAddress), .oOwner(oOwner), .oPreempt(oPreempt)
  );

  note_source_arbiter #(.MIN_HOLD(0), .GAP_TICKS(0)) dutZ (
    .iClk(iClk), .iReset_n(iReset_n), .iTick(zTick), .iReq(zReq),
    .oAddress(zAddress), .oOwner(zOwner), .oPreempt(zPreempt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // One clock edge with iTick driven as given, then settle 1 time unit past the edge.
  task automatic step(input logic t);
    iTick = t;
    @(posedge iClk);
    #1;
    iTick = 1'b0;
  endtask

  // Asynchronous reset pulse placed well away from any clock edge.
  task automatic pulseReset();
    iReset_n = 1'b0;
    #2;
    iReset_n = 1'b1;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0; iTick = 1'b0; iReq = 3'b000; zTick = 1'b0; zReq = 3'b000;
    #12;
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL reset_state got %b required %b", {oAddress, oOwner, oPreempt}, 7'b0);
    end
    nCompared++;
    if ({zAddress, zOwner, zPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL reset_state_z got %b required %b", {zAddress, zOwner, zPreempt}, 7'b0);
    end
    @(posedge iClk); #1;
    iReset_n = 1'b1;
    // Reset mid-grant.
    iReq = 3'b010;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd2, 2'd2}) begin
      nMismatched++; $display("FAIL reset_pre_grant got %h/%0d required 2/2", oAddress, oOwner);
    end
    iReset_n = 1'b0;
    #1;
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL reset_async got %h/%0d required 0/0", oAddress, oOwner);
    end
    repeat (3) @(posedge iClk);
    #2;
    nCompared++;
    if ({oAddress, oOwner} !== {4'd0, 2'd0}) begin
      nMismatched++; $display("FAIL reset_held got %h/%0d required 0/0", oAddress, oOwner);
    end
    iReset_n = 1'b1;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd2, 2'd2, 1'b0}) begin
      nMismatched++; $display("FAIL reset_regrant got %h/%0d required 2/2", oAddress, oOwner);
    end
  endtask

  task automatic test_priority();
    pulseReset();
    iReq = 3'b110;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd2, 2'd2}) begin
      nMismatched++; $display("FAIL prio_grant got %h/%0d required 2/2", oAddress, oOwner);
    end
    iReq = 3'b100;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL prio_gap_enter got %h/%0d/%b required 0/0/0", oAddress, oOwner, oPreempt);
    end
    step(1'b1);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd0, 2'd0}) begin
      nMismatched++; $display("FAIL prio_gap_tick got %h/%0d required 0/0", oAddress, oOwner);
    end
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd4, 2'd3}) begin
      nMismatched++; $display("FAIL prio_src3 got %h/%0d required 4/3", oAddress, oOwner);
    end
  endtask

  task automatic test_min_hold();
    pulseReset();
    iReq = 3'b100;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd4, 2'd3}) begin
      nMismatched++; $display("FAIL hold_grant got %h/%0d required 4/3", oAddress, oOwner);
    end
    iReq = 3'b101;
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c < 9; c++) begin
        step(1'b0);
        nCompared++;
        if ({oAddress, oOwner, oPreempt} !== {4'd4, 2'd3, 1'b0}) begin
          nMismatched++; $display("FAIL hold_dwell tick%0d cyc%0d got %h/%0d/%b required 4/3/0", k, c, oAddress, oOwner, oPreempt);
        end
      end
      step(1'b1);
      nCompared++;
      if ({oAddress, oOwner, oPreempt} !== {4'd4, 2'd3, 1'b0}) begin
        nMismatched++; $display("FAIL hold_at_tick%0d got %h/%0d/%b required 4/3/0", k, oAddress, oOwner, oPreempt);
      end
    end
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b1}) begin
      nMismatched++; $display("FAIL hold_preempt got %h/%0d/%b required 0/0/1", oAddress, oOwner, oPreempt);
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0);
      nCompared++;
      if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
        nMismatched++; $display("FAIL hold_gap cyc%0d got %h/%0d/%b required 0/0/0", c, oAddress, oOwner, oPreempt);
      end
    end
    step(1'b1);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd0, 2'd0}) begin
      nMismatched++; $display("FAIL hold_gap_tick got %h/%0d required 0/0", oAddress, oOwner);
    end
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd1, 2'd1, 1'b0}) begin
      nMismatched++; $display("FAIL hold_src1 got %h/%0d/%b required 1/1/0", oAddress, oOwner, oPreempt);
    end
  endtask

  task automatic test_regrant();
    pulseReset();
    iReq = 3'b001;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner} !== {4'd1, 2'd1}) begin
      nMismatched++; $display("FAIL regrant_first got %h/%0d required 1/1", oAddress, oOwner);
    end
    iReq = 3'b000;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL regrant_release got %h/%0d/%b required 0/0/0", oAddress, oOwner, oPreempt);
    end
    iReq = 3'b001;
    step(1'b1);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL regrant_gap got %h/%0d/%b required 0/0/0", oAddress, oOwner, oPreempt);
    end
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd1, 2'd1, 1'b0}) begin
      nMismatched++; $display("FAIL regrant_again got %h/%0d/%b required 1/1/0", oAddress, oOwner, oPreempt);
    end
  endtask

  task automatic test_simultaneous();
    pulseReset();
    iReq = 3'b010;
    step(1'b0);
    repeat (5) step(1'b1);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd2, 2'd2, 1'b0}) begin
      nMismatched++; $display("FAIL simul_held got %h/%0d/%b required 2/2/0", oAddress, oOwner, oPreempt);
    end
    iReq = 3'b001;
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd0, 2'd0, 1'b0}) begin
      nMismatched++; $display("FAIL simul_release got %h/%0d/%b required 0/0/0", oAddress, oOwner, oPreempt);
    end
    step(1'b1);
    step(1'b0);
    nCompared++;
    if ({oAddress, oOwner, oPreempt} !== {4'd1, 2'd1, 1'b0}) begin
      nMismatched++; $display("FAIL simul_src1 got %h/%0d/%b required 1/1/0", oAddress, oOwner, oPreempt);
    end
  endtask

  task automatic test_zero_hold_gap();
    iReq = 3'b000;
    pulseReset();
    zReq = 3'b100;
    step(1'b0);
    nCompared++;
    if ({zAddress, zOwner, zPreempt} !== {4'd4, 2'd3, 1'b0}) begin
      nMismatched++; $display("FAIL zero_grant got %h/%0d/%b required 4/3/0", zAddress, zOwner, zPreempt);
    end
    zReq = 3'b101;
    step(1'b0);
    nCompared++;
    if ({zAddress, zOwner, zPreempt} !== {4'd0, 2'd0, 1'b1}) begin
      nMismatched++; $display("FAIL zero_preempt got %h/%0d/%b required 0/0/1", zAddress, zOwner, zPreempt);
    end
    step(1'b0);
    nCompared++;
    if ({zAddress, zOwner, zPreempt} !== {4'd1, 2'd1, 1'b0}) begin
      nMismatched++; $display("FAIL zero_src1 got %h/%0d/%b required 1/1/0", zAddress, zOwner, zPreempt);
    end
    step(1'b0);
    nCompared++;
    if ({zAddress, zOwner, zPreempt} !== {4'd1, 2'd1, 1'b0}) begin
      nMismatched++; $display("FAIL zero_hold1 got %h/%0d/%b required 1/1/0", zAddress, zOwner, zPreempt);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_priority();
    test_min_hold();
    test_regrant();
    test_simultaneous();
    test_zero_hold_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
